// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback over one ALU and one memory port.
// Latency: outputs are combinational from state and mem_ready; lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles with zero waits.
// Backpressure: the FSM holds in FETCH/MEMRD/MEMWR until mem_ready; an optional watchdog abandons the access after MEM_TIMEOUT waits.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset (to IDLE)
//   opcode            IR[31:26], sampled in DECODE and MEMADR
//   mem_ready         memory completes the current access this cycle
//   pc_write..pc_src  multicycle datapath controls (see decode below)
//   illegal_op        one-cycle pulse while in ILLEGAL
//   mem_timeout       one-cycle pulse while in TIMEOUT
//   state             current state encoding, for debug
module mips_multicycle_control #(
  parameter int ENABLE_ADDI = 1,
  parameter int ENABLE_JUMP = 1,
  parameter int MEM_TIMEOUT = 0,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dest,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state
);

  // State encodings
  localparam logic [3:0] S_IDLE    = 4'h0;
  localparam logic [3:0] S_FETCH   = 4'h1;
  localparam logic [3:0] S_DECODE  = 4'h2;
  localparam logic [3:0] S_MEMADR  = 4'h3;
  localparam logic [3:0] S_MEMRD   = 4'h4;
  localparam logic [3:0] S_MEMWB   = 4'h5;
  localparam logic [3:0] S_MEMWR   = 4'h6;
  localparam logic [3:0] S_EXEC    = 4'h7;
  localparam logic [3:0] S_ALUWB   = 4'h8;
  localparam logic [3:0] S_BRANCH  = 4'h9;
  localparam logic [3:0] S_ADDIEX  = 4'hA;
  localparam logic [3:0] S_ADDIWB  = 4'hB;
  localparam logic [3:0] S_JUMP    = 4'hC;
  localparam logic [3:0] S_ILLEGAL = 4'hD;
  localparam logic [3:0] S_TIMEOUT = 4'hE;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic in_wait;      // currently in a state that waits on mem_ready
  logic next_wait;    // next state waits on mem_ready
  logic timeout_hit;  // watchdog fires this cycle (mem_ready=1 takes priority)

  assign state = state_q;

  assign in_wait   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign next_wait = (state_d == S_FETCH) || (state_d == S_MEMRD) || (state_d == S_MEMWR);

  always_comb begin
    timeout_hit = 1'b0;
    if (MEM_TIMEOUT != 0) begin
      timeout_hit = in_wait && !mem_ready && (cnt_q == TIMEOUT_VAL);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        if (mem_ready)        state_d = S_DECODE;
        else if (timeout_hit) state_d = S_TIMEOUT;
      end

      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = (ENABLE_ADDI != 0) ? S_ADDIEX : S_ILLEGAL;
          OP_J:         state_d = (ENABLE_JUMP != 0) ? S_JUMP : S_ILLEGAL;
          default:      state_d = S_ILLEGAL;
        endcase
      end

      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;

      S_MEMRD: begin
        if (mem_ready)        state_d = S_MEMWB;
        else if (timeout_hit) state_d = S_TIMEOUT;
      end

      S_MEMWR: begin
        if (mem_ready)        state_d = S_FETCH;
        else if (timeout_hit) state_d = S_TIMEOUT;
      end

      S_MEMWB:   state_d = S_FETCH;
      S_EXEC:    state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      // PC was already incremented in FETCH, so returning to FETCH skips the bad word.
      S_ILLEGAL: state_d = S_FETCH;
      S_TIMEOUT: state_d = S_FETCH;
      default:   state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Wait counter: restarts on every entry into a waiting state (including
  // MEMWR -> FETCH and TIMEOUT -> FETCH), counts stalled cycles, saturates.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    if (next_wait && (state_d != state_q)) begin
      cnt_d = '0;
    end else if (in_wait && !mem_ready && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Moore output decode. Only FETCH looks at mem_ready, so that IR and PC are
  // loaded exactly in the cycle the instruction word arrives. Reset forces
  // state_q to IDLE, which drives every output low.
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dest      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_src        = 2'b00;
    illegal_op    = 1'b0;
    mem_timeout   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;      // PC + 4
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;      // speculative branch target into ALUOut
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dest  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end
      S_ILLEGAL: illegal_op  = 1'b1;
      S_TIMEOUT: mem_timeout = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control. Two instances share inputs:
// dut_a uses default parameters, dut_b has ADDI disabled and MEM_TIMEOUT=4.
// Each cycle the stimulus pushes the expected state/outputs of one instance;
// a negedge monitor pops and compares.
module tb_mips_multicycle_control;

  localparam logic [3:0] I  = 4'h0, F  = 4'h1, D  = 4'h2, MA = 4'h3, MR = 4'h4;
  localparam logic [3:0] MB = 4'h5, MW = 4'h6, EX = 4'h7, AW = 4'h8, BR = 4'h9;
  localparam logic [3:0] AE = 4'hA, AB = 4'hB, JP = 4'hC, IL = 4'hD, TO = 4'hE;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic       mem_ready = 1'b0;

  // {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dest,
  //  mem_to_reg, reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0],
  //  pc_src[1:0], illegal_op, mem_timeout}
  logic [17:0] o_a, o_b;
  logic [3:0]  st_a, st_b;

  always #5 clk = ~clk;

  mips_multicycle_control dut_a (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(o_a[17]), .pc_write_cond(o_a[16]), .iord(o_a[15]),
    .mem_read(o_a[14]), .mem_write(o_a[13]), .ir_write(o_a[12]),
    .reg_dest(o_a[11]), .mem_to_reg(o_a[10]), .reg_write(o_a[9]),
    .alu_src_a(o_a[8]), .alu_src_b(o_a[7:6]), .alu_op(o_a[5:4]),
    .pc_src(o_a[3:2]), .illegal_op(o_a[1]), .mem_timeout(o_a[0]),
    .state(st_a)
  );

  mips_multicycle_control #(.ENABLE_ADDI(0), .ENABLE_JUMP(1), .MEM_TIMEOUT(4), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(o_b[17]), .pc_write_cond(o_b[16]), .iord(o_b[15]),
    .mem_read(o_b[14]), .mem_write(o_b[13]), .ir_write(o_b[12]),
    .reg_dest(o_b[11]), .mem_to_reg(o_b[10]), .reg_write(o_b[9]),
    .alu_src_a(o_b[8]), .alu_src_b(o_b[7:6]), .alu_op(o_b[5:4]),
    .pc_src(o_b[3:2]), .illegal_op(o_b[1]), .mem_timeout(o_b[0]),
    .state(st_b)
  );

  typedef struct packed {
    logic        sel;   // 0 = dut_a, 1 = dut_b
    logic [3:0]  st;
    logic [17:0] o;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   step    = 0;

  // Expected outputs for a state, written from the control table.
  function automatic logic [17:0] exp_outs(input logic [3:0] st, input logic mr);
    logic pw, pwc, iord_e, mrd, mwr, irw, rd, m2r, rw, asa, ill, tmo;
    logic [1:0] asb, aop, psrc;
    pw = 0; pwc = 0; iord_e = 0; mrd = 0; mwr = 0; irw = 0; rd = 0; m2r = 0;
    rw = 0; asa = 0; ill = 0; tmo = 0; asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      F:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      D:  asb = 2'b11;
      MA: begin asa = 1; asb = 2'b10; end
      MR: begin mrd = 1; iord_e = 1; end
      MB: begin rw = 1; m2r = 1; end
      MW: begin mwr = 1; iord_e = 1; end
      EX: begin asa = 1; aop = 2'b10; end
      AW: begin rw = 1; rd = 1; end
      BR: begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
      AE: begin asa = 1; asb = 2'b10; end
      AB: rw = 1;
      JP: begin pw = 1; psrc = 2'b10; end
      IL: ill = 1;
      TO: tmo = 1;
      default: ;
    endcase
    return {pw, pwc, iord_e, mrd, mwr, irw, rd, m2r, rw, asa, asb, aop, psrc, ill, tmo};
  endfunction

  // One clock cycle: drive inputs just after the edge and record what the
  // selected instance must show for the rest of this cycle.
  task automatic cyc(input logic sel, input logic [5:0] op, input logic mr,
                     input logic [3:0] st, input logic rst_v);
    exp_t e;
    @(posedge clk);
    #1;
    opcode    = op;
    mem_ready = mr;
    rst_n     = rst_v;
    e.sel = sel;
    e.st  = st;
    e.o   = exp_outs(st, mr);
    q.push_back(e);
  endtask

  task automatic do_reset(input logic sel);
    cyc(sel, 6'h00, 1'b0, I, 1'b0);
    cyc(sel, 6'h00, 1'b0, I, 1'b0);
  endtask

  // Monitor: compare the selected instance mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [3:0]  ast;
      logic [17:0] ao;
      e   = q.pop_front();
      ast = e.sel ? st_b : st_a;
      ao  = e.sel ? o_b : o_a;
      step++;
      n_tests++;
      if (ast !== e.st) begin
        n_fail++;
        $display("FAIL state step %0d dut%0d: got %h expected %h", step, e.sel, ast, e.st);
      end
      n_tests++;
      if (ao !== e.o) begin
        n_fail++;
        $display("FAIL outputs step %0d dut%0d state %h: got %b expected %b",
                 step, e.sel, e.st, ao, e.o);
      end
    end
  end

  initial begin
    // ---------------- dut_a: default parameters ----------------
    do_reset(0);
    cyc(0, 6'h23, 1, I,  1);          // release reset; still IDLE this cycle
    // lw, zero waits: 1,2,3,4,5
    cyc(0, 6'h23, 1, F,  1);
    cyc(0, 6'h23, 1, D,  1);
    cyc(0, 6'h23, 1, MA, 1);
    cyc(0, 6'h23, 1, MR, 1);
    cyc(0, 6'h23, 1, MB, 1);
    // R-type with three stalled FETCH cycles
    cyc(0, 6'h00, 0, F,  1);
    cyc(0, 6'h00, 0, F,  1);
    cyc(0, 6'h00, 0, F,  1);
    cyc(0, 6'h00, 1, F,  1);
    cyc(0, 6'h00, 1, D,  1);
    cyc(0, 6'h00, 1, EX, 1);
    cyc(0, 6'h00, 1, AW, 1);
    // beq
    cyc(0, 6'h04, 1, F,  1);
    cyc(0, 6'h04, 1, D,  1);
    cyc(0, 6'h04, 1, BR, 1);
    // j
    cyc(0, 6'h02, 1, F,  1);
    cyc(0, 6'h02, 1, D,  1);
    cyc(0, 6'h02, 1, JP, 1);
    // addi enabled
    cyc(0, 6'h08, 1, F,  1);
    cyc(0, 6'h08, 1, D,  1);
    cyc(0, 6'h08, 1, AE, 1);
    cyc(0, 6'h08, 1, AB, 1);
    // undecoded opcode
    cyc(0, 6'h3F, 1, F,  1);
    cyc(0, 6'h3F, 1, D,  1);
    cyc(0, 6'h3F, 1, IL, 1);
    // sw, zero waits
    cyc(0, 6'h2B, 1, F,  1);
    cyc(0, 6'h2B, 1, D,  1);
    cyc(0, 6'h2B, 1, MA, 1);
    cyc(0, 6'h2B, 1, MW, 1);
    cyc(0, 6'h2B, 1, F,  1);

    // ---------------- dut_b: no ADDI, MEM_TIMEOUT=4 ----------------
    do_reset(1);
    cyc(1, 6'h08, 1, I,  1);
    cyc(1, 6'h08, 1, F,  1);
    cyc(1, 6'h08, 1, D,  1);
    cyc(1, 6'h08, 1, IL, 1);          // addi disabled -> illegal
    // sw with memory never ready: five MEMWR cycles then TIMEOUT
    cyc(1, 6'h2B, 1, F,  1);
    cyc(1, 6'h2B, 1, D,  1);
    cyc(1, 6'h2B, 1, MA, 1);
    for (int i = 0; i < 5; i++) cyc(1, 6'h2B, 0, MW, 1);
    cyc(1, 6'h2B, 1, TO, 1);
    // same, but mem_ready arrives on the 5th cycle: completes, no timeout
    cyc(1, 6'h2B, 1, F,  1);
    cyc(1, 6'h2B, 1, D,  1);
    cyc(1, 6'h2B, 1, MA, 1);
    for (int i = 0; i < 4; i++) cyc(1, 6'h2B, 0, MW, 1);
    cyc(1, 6'h2B, 1, MW, 1);
    // instruction fetch that times out, then a normal R-type
    for (int i = 0; i < 5; i++) cyc(1, 6'h00, 0, F, 1);
    cyc(1, 6'h00, 1, TO, 1);
    cyc(1, 6'h00, 1, F,  1);
    cyc(1, 6'h00, 1, D,  1);
    cyc(1, 6'h00, 1, EX, 1);
    cyc(1, 6'h00, 1, AW, 1);
    // lw stalled in MEMRD, reset asserted mid-access
    cyc(1, 6'h23, 1, F,  1);
    cyc(1, 6'h23, 1, D,  1);
    cyc(1, 6'h23, 1, MA, 1);
    cyc(1, 6'h23, 0, MR, 1);
    cyc(1, 6'h23, 0, MR, 1);
    cyc(1, 6'h23, 0, I,  0);          // state is MEMRD at the edge; reset drops it now
    cyc(1, 6'h23, 1, I,  0);
    cyc(1, 6'h23, 1, I,  1);          // release: IDLE this cycle, FETCH next
    cyc(1, 6'h23, 1, F,  1);
    cyc(1, 6'h23, 1, D,  1);

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
